imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the immediate extender: takes a 32-bit signed immediate, an ImmSrc type code and a base instruction word.
- Scatters the immediate into the I/S/B bit fields of the instruction, producing the packed 32-bit instruction.
- Emits the word together with a sequential instruction-memory word address, for program loading and self-checking benches.
- Valid/ready on both sides, 2-entry output buffer, range checking, running address and error counters.

Parameters:
- BASE_ADDR, 32'h0000_0000, address given to the first emitted word after reset or flush.
- ADDR_STEP, 4, byte increment of out_addr per accepted word.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; empties the buffer and reloads the address counter to BASE_ADDR (error counter kept).
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_imm  in  32  signed immediate value.
- req_immsrc  in  2  00 I, 01 S, 10 B, 11 none (pass-through).
- req_base  in  32  instruction with opcode/rd/rs1/rs2/funct set; its immediate-field bits are ignored.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  consumer takes the head when out_valid && out_ready.
- out_instr  out  32  packed instruction.
- out_addr  out  32  byte address assigned to out_instr.
- out_err  out  1  immediate not representable for this word.
- err_count  out  ERRCNT_W  saturating count of accepted requests with err=1.

Behaviour:
- Reset: buffer empty; out_valid=0, out_instr=0, out_addr=0, out_err=0, err_count=0, address counter=BASE_ADDR; req_ready=1 in the cycle after reset deasserts.
- Packing (combinational on the request, registered into the buffer):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - 11: req_base passed unchanged.
  - All bits outside the selected fields come from req_base.
- Range rules:
  - I/S: err unless imm[31:11] are all equal.
  - B: err unless imm[31:12] are all equal and imm[0]==0.
  - 11: never err.
  - On err the word is still packed (truncated) and emitted with out_err=1.
- Round-trip invariant: for err=0 and type 00/01/10, the extender applied to out_instr[31:7] with the same ImmSrc returns req_imm exactly.
- Buffer:
  - 2-entry FIFO with occupancy 0..2; req_ready = (occupancy<2).
  - Latency: a word accepted in cycle N is visible on out_* in cycle N+1 if the buffer was empty.
  - Simultaneous accept and pop: occupancy unchanged, order preserved.
  - Full (2) with out_ready=0: req_ready=0 and nothing is lost.
  - out_* hold stable while out_valid && !out_ready.
- Address: each accepted request takes the current counter value, then the counter adds ADDR_STEP, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000 with the default step).
- err_count increments on acceptance of an err word and saturates at all-ones.
- Flush:
  - Buffer empty, out_valid=0, counter=BASE_ADDR, err_count unchanged.
  - A request presented in the flush cycle is dropped; req_ready=0 during flush.
- reset outranks flush; reset mid-stream discards all buffered words.

Optional Feature:
- IMM_ENCODER_RANGE_CHECK_EN
  - Defined: range rules above apply; out_err and err_count are live.
  - Undefined: no checking logic; out_err tied 0, err_count tied 0, immediates silently truncated; packing and timing unchanged.

Test Plan:
- I pack: base 0x00000013, imm 0xFFFFFFFF, src 00 -> out_instr 0xFFF00013, out_addr BASE_ADDR, out_err 0, one cycle after accept.
- S pack: base 0x00002023, imm 0x000007FC, src 01 -> 0x7E002E23; B pack: base 0x00000063, imm 0xFFFFFFFC, src 10 -> 0xFE000EE3; the two addresses are consecutive (+4).
- Range errors (macro defined): I imm 0x00000800 -> out_err 1, out_instr[31:20]=0x800; B imm 0x00000003 -> out_err 1; err_count=2. Macro undefined -> out_err 0, err_count 0.
- Backpressure: hold out_ready=0, offer 3 requests -> 2 accepted, req_ready=0 on the third; release out_ready -> words appear in order, addresses +4 each, third then accepted.
- Flush/wrap: BASE_ADDR=0xFFFFFFF8, send 3 words -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; flush with 2 buffered -> out_valid 0 next cycle, next word gets 0xFFFFFFF8.
- Random round-trip: 1000 random imm/src with err=0 -> extender(out_instr[31:7], src) == req_imm; reset asserted mid-burst -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/imm_encoder.sv
// Immediate encoder: packs a signed immediate into I/S/B fields and tags each word with an address (IMM_ENCODER_RANGE_CHECK_EN enables range errors).
// One cycle from accept to out_* when empty; 2-entry buffer, req_ready low when full, in reset or during flush.

module imm_encoder_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           wr_dat,
    input  logic                   pop,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    // Pointers wrap naturally, so DEPTH must be a power of two.
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_dat;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = cnt_q;
endmodule

module imm_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int          ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_imm,
    input  logic [1:0]          req_immsrc,
    input  logic [31:0]         req_base,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [31:0]         out_addr,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_count
);
    typedef enum logic [1:0] {
        SRC_I    = 2'b00,
        SRC_S    = 2'b01,
        SRC_B    = 2'b10,
        SRC_NONE = 2'b11
    } immsrc_e;

    typedef struct packed {
        logic        err;
        logic [31:0] addr;
        logic [31:0] instr;
    } entry_t;

    logic [31:0] packed_instr;
    logic        pack_err;
    logic        accept;
    logic        pop;
    logic [1:0]  occ;
    logic [31:0] addr_q, addr_d;
    entry_t      wr_entry;
    entry_t      head;

    // Fields not selected by the immediate type keep the base word's bits.
    always_comb begin
        packed_instr = req_base;
        case (immsrc_e'(req_immsrc))
            SRC_I: packed_instr[31:20] = req_imm[11:0];
            SRC_S: begin
                packed_instr[31:25] = req_imm[11:5];
                packed_instr[11:7]  = req_imm[4:0];
            end
            SRC_B: begin
                packed_instr[31]    = req_imm[12];
                packed_instr[30:25] = req_imm[10:5];
                packed_instr[11:8]  = req_imm[4:1];
                packed_instr[7]     = req_imm[11];
            end
            default: packed_instr = req_base;
        endcase
    end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    logic                sext12_ok;
    logic                sext13_ok;
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

    assign sext12_ok = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    assign sext13_ok = (&req_imm[31:12]) | ~(|req_imm[31:12]);

    always_comb begin
        case (immsrc_e'(req_immsrc))
            SRC_I, SRC_S: pack_err = !sext12_ok;
            SRC_B:        pack_err = !sext13_ok || req_imm[0];
            default:      pack_err = 1'b0;
        endcase
    end

    always_comb begin
        errcnt_d = errcnt_q;
        if (accept && pack_err && !(&errcnt_q)) begin
            errcnt_d = errcnt_q + 1'b1;
        end
    end

    // Flush deliberately leaves the error count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign err_count = errcnt_q;
`else
    logic unused_imm_bits;

    assign pack_err        = 1'b0;
    assign err_count       = '0;
    assign unused_imm_bits = ^{req_imm[31:13], req_imm[0]};
`endif

    assign req_ready = !reset && !flush && (occ < 2'd2);
    assign accept    = req_valid && req_ready;
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        addr_d = addr_q;
        if (flush) begin
            addr_d = BASE_ADDR;
        end else if (accept) begin
            addr_d = addr_q + ADDR_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= BASE_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign wr_entry = '{err: pack_err, addr: addr_q, instr: packed_instr};

    imm_encoder_fifo #(
        .W    ($bits(entry_t)),
        .DEPTH(2)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (accept),
        .wr_dat(wr_entry),
        .pop   (pop),
        .rd_dat(head),
        .count (occ)
    );

    assign out_instr = head.instr;
    assign out_addr  = head.addr;
    assign out_err   = head.err;
endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: vector table, directed backpressure/flush/reset sequences and a random round-trip burst.
module tb_imm_encoder;
    localparam logic [31:0] BASE     = 32'hFFFF_FFF8;
    localparam int          ERRCNT_W = 8;
`ifdef IMM_ENCODER_RANGE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset, flush, req_valid, req_ready;
    logic [31:0]         req_imm, req_base, out_instr, out_addr;
    logic [1:0]          req_immsrc;
    logic                out_valid, out_ready, out_err;
    logic [ERRCNT_W-1:0] err_count;

    imm_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(32'd4), .ERRCNT_W(ERRCNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_imm(req_imm),
        .req_immsrc(req_immsrc), .req_base(req_base),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
        logic [31:0] imm;
        logic [1:0]  src;
        bit          rt;
    } exp_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] imm;
        logic [1:0]  src;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] addr_m = BASE;
    logic [7:0]  errcnt_m = 8'd0;
    bit          mon_en = 1'b0;
    bit          rnd_ready = 1'b0;
    logic [31:0] drv_instr, drv_imm;
    logic [1:0]  drv_src;
    logic        drv_err;
    bit          drv_rt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_pack(input logic [31:0] imm, input logic [1:0] src, input logic [31:0] base);
        case (src)
            2'b00:   return (base & 32'h000F_FFFF) | (imm << 20);
            2'b01:   return (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            2'b10:   return (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                            | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            default: return base;
        endcase
    endfunction

    function automatic logic m_err(input logic [31:0] imm, input logic [1:0] src);
        int  s;
        logic r;
        s = imm;
        case (src)
            2'b00, 2'b01: r = (s < -2048) || (s > 2047);
            2'b10:        r = (s < -4096) || (s > 4095) || imm[0];
            default:      r = 1'b0;
        endcase
        return CHK_EN && r;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] ins, input logic [1:0] src);
        case (src)
            2'b00:   return {{20{ins[31]}}, ins[31:20]};
            2'b01:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            2'b10:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            default: return ins;
        endcase
    endfunction

    // Scoreboard: checks flow-control state, pops on output handshake, pushes on input handshake.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
            chk("req_ready", 32'(req_ready), 32'(!reset && !flush && sb_q.size() < 2));
            chk("err_count", 32'(err_count), 32'(errcnt_m));
            if (out_valid && out_ready && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("out_instr", out_instr, e.instr);
                chk("out_addr", out_addr, e.addr);
                chk("out_err", 32'(out_err), 32'(e.err));
                if (e.rt) chk("roundtrip", m_ext(out_instr, e.src), e.imm);
            end
            if (reset) begin
                sb_q.delete();
                addr_m   = BASE;
                errcnt_m = 8'd0;
            end else if (flush) begin
                sb_q.delete();
                addr_m = BASE;
            end else if (req_valid && req_ready) begin
                e.instr = drv_instr;
                e.addr  = addr_m;
                e.err   = drv_err;
                e.imm   = drv_imm;
                e.src   = drv_src;
                e.rt    = drv_rt;
                sb_q.push_back(e);
                addr_m = addr_m + 32'd4;
                if (drv_err && errcnt_m != 8'hFF) errcnt_m = errcnt_m + 8'd1;
            end
        end
    end

    task automatic send(input logic [31:0] base, input logic [31:0] imm, input logic [1:0] src,
                        input logic [31:0] exp_instr, input logic exp_err, input bit rt);
        int t;
        req_base = base; req_imm = imm; req_immsrc = src;
        drv_instr = exp_instr; drv_err = exp_err; drv_imm = imm; drv_src = src; drv_rt = rt;
        req_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            if (t == 200) begin
                n_chk++; n_err++;
                $display("FAIL send_timeout: req_ready 0 for 200 cycles, expected 1");
                break;
            end
            t++;
            @(posedge clk); #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        int t;
        out_ready = 1'b1;
        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t == 500) begin
            n_chk++; n_err++;
            $display("FAIL drain_timeout: %0d words left, expected 0", sb_q.size());
        end
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[10];
        logic [31:0] r, imm;
        logic [1:0]  src;

        tbl[0] = '{32'h0000_0013, 32'hFFFF_FFFF, 2'b00, 32'hFFF0_0013, 1'b0};
        tbl[1] = '{32'h0000_2023, 32'h0000_07FC, 2'b01, 32'h7E00_2E23, 1'b0};
        tbl[2] = '{32'h0000_0063, 32'hFFFF_FFFC, 2'b10, 32'hFE00_0EE3, 1'b0};
        tbl[3] = '{32'h0000_0013, 32'h0000_0800, 2'b00, 32'h8000_0013, 1'b1};
        tbl[4] = '{32'h0000_0063, 32'h0000_0003, 2'b10, 32'h0000_0163, 1'b1};
        tbl[5] = '{32'h0000_0013, 32'hFFFF_F800, 2'b00, 32'h8000_0013, 1'b0};
        tbl[6] = '{32'h1234_5678, 32'hDEAD_BEEF, 2'b11, 32'h1234_5678, 1'b0};
        tbl[7] = '{32'h0000_0063, 32'h0000_0FFE, 2'b10, 32'h7E00_0FE3, 1'b0};
        tbl[8] = '{32'h0000_0063, 32'h0000_1000, 2'b10, 32'h8000_0063, 1'b1};
        tbl[9] = '{32'h0000_2023, 32'hFFFF_F7FF, 2'b01, 32'h7E00_2FA3, 1'b1};

        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
        req_imm = '0; req_base = '0; req_immsrc = '0;
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'h1);
        @(posedge clk); #1;

        // Directed vectors; first word latency and address checked by hand.
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].base, tbl[i].imm, tbl[i].src, tbl[i].instr, CHK_EN && tbl[i].err,
                 (tbl[i].src != 2'b11) && !tbl[i].err);
            if (i == 0) begin
                @(negedge clk);
                chk("first_latency_valid", 32'(out_valid), 32'h1);
                chk("first_instr", out_instr, 32'hFFF0_0013);
                chk("first_addr", out_addr, BASE);
                @(posedge clk); #1;
            end
        end
        drain();
        chk("err_count_table", 32'(err_count), CHK_EN ? 32'd4 : 32'd0);

        // Backpressure: two fill the buffer, the third waits.
        out_ready = 1'b0;
        send(32'h0000_0013, 32'h0000_0005, 2'b00, 32'h0050_0013, 1'b0, 1'b1);
        send(32'h0000_2023, 32'hFFFF_FFE0, 2'b01, 32'hFE00_2023, 1'b0, 1'b1);
        req_base = 32'h0000_0063; req_imm = 32'h0000_0008; req_immsrc = 2'b10;
        drv_instr = 32'h0000_0463; drv_err = 1'b0; drv_imm = 32'h8; drv_src = 2'b10; drv_rt = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        chk("full_req_ready", 32'(req_ready), 32'h0);
        chk("stall_instr", out_instr, 32'h0050_0013);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_hold_instr", out_instr, 32'h0050_0013);
        chk("stall_hold_addr", out_addr, addr_m - 32'd8);
        @(posedge clk); #1 out_ready = 1'b1;
        send(32'h0000_0063, 32'h0000_0008, 2'b10, 32'h0000_0463, 1'b0, 1'b1);
        drain();

        // Flush with two buffered words; the request offered during flush is dropped.
        out_ready = 1'b0;
        send(32'h0000_0013, 32'h0000_0001, 2'b00, 32'h0010_0013, 1'b0, 1'b1);
        send(32'h0000_0013, 32'h0000_0002, 2'b00, 32'h0020_0013, 1'b0, 1'b1);
        flush = 1'b1; req_valid = 1'b1; req_imm = 32'h3;
        @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1 out_ready = 1'b1;
        send(32'h0000_0013, 32'h0000_0007, 2'b00, 32'h0070_0013, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush_addr", out_addr, BASE);
        @(posedge clk); #1;
        drain();

        // Random in-range immediates with random output stalls.
        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            src = 2'($urandom_range(0, 2));
            r   = $urandom;
            imm = (src == 2'b10) ? {{19{r[12]}}, r[12:1], 1'b0} : {{20{r[11]}}, r[11:0]};
            r   = $urandom;
            send(r, imm, src, m_pack(imm, src, r), m_err(imm, src), 1'b1);
        end
        rnd_ready = 1'b0;
        drain();

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            send(32'h0000_0013, 32'h0000_0800, 2'b00, 32'h8000_0013, CHK_EN, 1'b0);
        end
        drain();
        chk("err_count_sat", 32'(err_count), CHK_EN ? 32'hFF : 32'h0);

        // Reset mid-stream discards buffered words.
        out_ready = 1'b0;
        send(32'h0000_0013, 32'h0000_0011, 2'b00, 32'h0110_0013, 1'b0, 1'b1);
        send(32'h0000_0013, 32'h0000_0022, 2'b00, 32'h0220_0013, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_instr", out_instr, 32'h0);
        chk("midrst_out_addr", out_addr, 32'h0);
        chk("midrst_out_err", 32'(out_err), 32'h0);
        chk("midrst_err_count", 32'(err_count), 32'h0);
        @(posedge clk); #1 out_ready = 1'b1;
        send(32'h0000_0013, 32'h0000_0033, 2'b00, 32'h0330_0013, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_reset_addr", out_addr, BASE);
        @(posedge clk); #1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
